// File: rtl/mmio_pkg.sv
// Shared constants for mmio_display_io: register map, STATUS bit layout and the hex glyph table.
// Glyphs are active-low {dp,g,f,e,d,c,b,a}; digit n lives at bits [8n+7:8n] of HEX_SEG.
package mmio_pkg;
   localparam logic [31:0] ADDR_SW     = 32'hFFFF_FFC0;
   localparam logic [31:0] ADDR_LED    = 32'hFFFF_FFC2;
   localparam logic [31:0] ADDR_SEG    = 32'hFFFF_FFF0;
   localparam logic [31:0] ADDR_BLANK  = 32'hFFFF_FFF4;
   localparam logic [31:0] ADDR_STATUS = 32'hFFFF_FFF8;

   localparam int ST_PEND = 0;
   localparam int ST_CONF = 1;
   localparam int ST_LZ   = 2;

   localparam logic [127:0] HEX_SEG = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   function automatic logic [7:0] hexToSeg(input logic [3:0] nib);
      return HEX_SEG[{nib, 3'b000} +: 8];
   endfunction
endpackage

// File: rtl/mmio_display_io_if.sv
// CPU data-memory side of mmio_display_io: byte address, write data, one-cycle we/re strobes, registered rdata.
interface mmio_display_io_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        we;
   logic        re;
   logic [31:0] rdata;

   modport master (output addr, wdata, we, re, input rdata);
   modport slave  (input addr, wdata, we, re, output rdata);
endinterface

// File: rtl/io_debounce.sv
// Two-flop synchroniser followed by a debouncer: the output takes the synchronised value once it has
// held still for DB_CYC cycles; any change of any bit restarts the count.
module io_debounce #(
   parameter int W      = 1,
   parameter int DB_CYC = 20
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] raw,
   output logic [W-1:0] clean
);
   localparam int            CW       = $clog2(DB_CYC + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYC - 1);

   logic [W-1:0]  meta;
   logic [W-1:0]  sync;
   logic [W-1:0]  last;
   logic [CW-1:0] stableCnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta      <= '0;
         sync      <= '0;
         last      <= '0;
         stableCnt <= '0;
         clean     <= '0;
      end else begin
         meta <= raw;
         sync <= meta;
         if (sync != last) begin
            last      <= sync;
            stableCnt <= '0;
         end else if (stableCnt == CNT_LAST) begin
            clean <= last;
         end else begin
            stableCnt <= stableCnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/mmio_display_io.sv
// MMIO controller for switches, confirm button, LEDs and a scanned seven-segment bank.
// Define MMIO_LZ_SUPPRESS_EN to add the STATUS[2] leading-zero suppression control.
module mmio_display_io
   import mmio_pkg::*;
#(
   parameter int LED_W    = 16,
   parameter int SW_W     = 16,
   parameter int DIGITS   = 8,
   parameter int SCAN_DIV = 100000,
   parameter int DB_CYC   = 20
) (
   input  logic              clk,
   input  logic              rst,
   mmio_display_io_if.slave  bus,
   input  logic [SW_W-1:0]   sw_in,
   input  logic              confirm_in,
   output logic [LED_W-1:0]  led_out,
   output logic [DIGITS-1:0] seg_sel,
   output logic [7:0]        seg_code
);
   localparam int            IW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int            PW         = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

   logic [4*DIGITS-1:0] segReg;
   logic [DIGITS-1:0]   blankReg;
   logic [DIGITS-1:0]   dimMask;
   logic [SW_W-1:0]     swDb;
   logic [SW_W-1:0]     swLatch;
   logic                confDb;
   logic                confPrev;
   logic                swPending;
   logic [PW-1:0]       presc;
   logic [IW-1:0]       scanIdx;
   logic [31:0]         statusWord;
   logic [31:0]         rdMux;
   logic                unusedWdata;

   assign unusedWdata = ^bus.wdata;

   io_debounce #(.W(SW_W), .DB_CYC(DB_CYC)) uSwDb (
      .clk(clk), .rst(rst), .raw(sw_in), .clean(swDb)
   );
   io_debounce #(.W(1), .DB_CYC(DB_CYC)) uConfDb (
      .clk(clk), .rst(rst), .raw(confirm_in), .clean(confDb)
   );

`ifdef MMIO_LZ_SUPPRESS_EN
   logic lzEn;
   logic zeroAbove;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) lzEn <= 1'b0;
      else if (bus.we && bus.addr == ADDR_STATUS) lzEn <= bus.wdata[ST_LZ];
   end
`endif

   always_comb begin
      statusWord          = '0;
      statusWord[ST_PEND] = swPending;
      statusWord[ST_CONF] = confDb;
`ifdef MMIO_LZ_SUPPRESS_EN
      statusWord[ST_LZ]   = lzEn;
`endif
   end

   always_comb begin
      rdMux = '0;
      case (bus.addr)
         ADDR_SW:     rdMux = 32'(swLatch);
         ADDR_LED:    rdMux = 32'(led_out);
         ADDR_SEG:    rdMux = 32'(segReg);
         ADDR_BLANK:  rdMux = 32'(blankReg);
         ADDR_STATUS: rdMux = statusWord;
         default:     rdMux = '0;
      endcase
   end

   // rdMux sees pre-edge register values, so a same-cycle we+re returns the old contents.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led_out   <= '0;
         segReg    <= '0;
         blankReg  <= '0;
         bus.rdata <= '0;
      end else begin
         if (bus.we) begin
            if (bus.addr == ADDR_LED)   led_out  <= bus.wdata[LED_W-1:0];
            if (bus.addr == ADDR_SEG)   segReg   <= bus.wdata[4*DIGITS-1:0];
            if (bus.addr == ADDR_BLANK) blankReg <= bus.wdata[DIGITS-1:0];
         end
         if (bus.re) bus.rdata <= rdMux;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         confPrev  <= 1'b0;
         swLatch   <= '0;
         swPending <= 1'b0;
      end else begin
         confPrev <= confDb;
         if (confDb && !confPrev) begin
            swLatch   <= swDb;
            swPending <= 1'b1;
         end else if (bus.re && bus.addr == ADDR_SW) begin
            swPending <= 1'b0;
         end
      end
   end

   always_comb begin
      dimMask = blankReg;
`ifdef MMIO_LZ_SUPPRESS_EN
      zeroAbove = 1'b1;
      if (lzEn) begin
         for (int i = DIGITS - 1; i >= 1; i--) begin
            zeroAbove  = zeroAbove & (segReg[4*i +: 4] == 4'h0);
            dimMask[i] = dimMask[i] | zeroAbove;
         end
      end
`endif
   end

   // Outputs reload only at the start of a slot, so a SEG write mid-slot cannot tear the glyph.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc    <= '0;
         scanIdx  <= '0;
         seg_sel  <= '1;
         seg_code <= 8'hFF;
      end else begin
         if (presc == PRESC_LAST) begin
            presc   <= '0;
            scanIdx <= (scanIdx == IDX_LAST) ? '0 : scanIdx + 1'b1;
         end else begin
            presc <= presc + 1'b1;
         end
         if (presc == '0) begin
            if (dimMask[scanIdx]) begin
               seg_sel  <= '1;
               seg_code <= 8'hFF;
            end else begin
               seg_sel  <= ~(DIGITS'(1) << scanIdx);
               seg_code <= hexToSeg(segReg[4*scanIdx +: 4]);
            end
         end
      end
   end
endmodule

// File: tb/tb_mmio_display_io.sv
// Bench for mmio_display_io: register table, scan/blank/reset/debounce/collision sequences, random bus traffic vs a register model.
module tb_mmio_display_io;
   localparam logic [31:0] A_SW     = 32'hFFFF_FFC0;
   localparam logic [31:0] A_LED    = 32'hFFFF_FFC2;
   localparam logic [31:0] A_SEG    = 32'hFFFF_FFF0;
   localparam logic [31:0] A_BLANK  = 32'hFFFF_FFF4;
   localparam logic [31:0] A_STATUS = 32'hFFFF_FFF8;
   localparam int          DIG      = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] sw_in;
   logic        confirm_in;
   logic [15:0] led_out;
   logic [7:0]  seg_sel;
   logic [7:0]  seg_code;

   mmio_display_io_if bus();

   mmio_display_io #(
      .LED_W(16), .SW_W(16), .DIGITS(DIG), .SCAN_DIV(4), .DB_CYC(4)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .sw_in(sw_in), .confirm_in(confirm_in),
      .led_out(led_out), .seg_sel(seg_sel), .seg_code(seg_code)
   );

   always #5 clk = ~clk;

   int nCmp = 0;
   int nBad = 0;

   logic [7:0] hexTbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // Register-level model of what the CPU should see.
   logic [15:0] mLed, mSw;
   logic [31:0] mSeg;
   logic [7:0]  mBlank;
   bit          mPend, mConf;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;
   vec_t vt [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] modelRead(input logic [31:0] a);
      logic [31:0] v;
      v = '0;
      if (a == A_SW)          v = {16'h0, mSw};
      else if (a == A_LED)    v = {16'h0, mLed};
      else if (a == A_SEG)    v = mSeg;
      else if (a == A_BLANK)  v = {24'h0, mBlank};
      else if (a == A_STATUS) v = {30'h0, mConf, mPend};
      return v;
   endfunction

   task automatic modelWrite(input logic [31:0] a, input logic [31:0] d);
      if (a == A_LED)   mLed   = d[15:0];
      if (a == A_SEG)   mSeg   = d;
      if (a == A_BLANK) mBlank = d[7:0];
   endtask

   task automatic busOp(input logic [31:0] a, input logic [31:0] d, input bit w, input bit r,
                        input logic [31:0] exp, input string name);
      @(negedge clk);
      bus.addr = a; bus.wdata = d; bus.we = w; bus.re = r;
      @(negedge clk);
      bus.we = 1'b0; bus.re = 1'b0;
      if (w) modelWrite(a, d);
      if (r) begin
         check(name, bus.rdata, exp);
         if (a == A_SW) mPend = 1'b0;
      end
   endtask

   task automatic waitSel(input logic [7:0] target, output bit ok);
      logic [7:0] prev;
      ok = 1'b0;
      prev = seg_sel;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (seg_sel == target && prev != target) begin
            ok = 1'b1;
            break;
         end
         prev = seg_sel;
      end
      if (!ok) begin
         nCmp++; nBad++;
         $display("FAIL waitSel: seg_sel never entered %h, last %h", target, seg_sel);
      end
   endtask

   // Walks nine full slots from digit 'first', four cycles each, against the model.
   task automatic scanCheck(input int first, input string name);
      bit ok;
      int k;
      logic [7:0] es, ec, one;
      one = 8'd1;
      waitSel(~(one << first), ok);
      if (ok) begin
         for (int s = 0; s <= DIG; s++) begin
            k  = (first + s) % DIG;
            es = mBlank[k] ? 8'hFF : ~(one << k);
            ec = mBlank[k] ? 8'hFF : hexTbl[mSeg[4*k +: 4]];
            for (int c = 0; c < 4; c++) begin
               check($sformatf("%s sel d%0d", name, k), {24'h0, seg_sel}, {24'h0, es});
               check($sformatf("%s code d%0d", name, k), {24'h0, seg_code}, {24'h0, ec});
               @(negedge clk);
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          ok;
      logic [31:0] a, d;
      bit          w, r;
      int          sel;

      sw_in = '0; confirm_in = 1'b0;
      bus.addr = '0; bus.wdata = '0; bus.we = 1'b0; bus.re = 1'b0;
      mLed = '0; mSw = '0; mSeg = '0; mBlank = '0; mPend = 1'b0; mConf = 1'b0;
      vt[0] = '{A_LED,    32'hDEAD_A5A5, 32'h0000_A5A5};
      vt[1] = '{A_SEG,    32'h1234_5678, 32'h1234_5678};
      vt[2] = '{A_BLANK,  32'hFFFF_FF81, 32'h0000_0081};
      vt[3] = '{A_BLANK,  32'h0000_0000, 32'h0000_0000};
      vt[4] = '{A_SW,     32'h0000_1234, 32'h0000_0000};
      vt[5] = '{A_STATUS, 32'hFFFF_FFFF, 32'h0000_0000};
      vt[6] = '{32'hFFFF_FFC4, 32'h0000_5A5A, 32'h0000_0000};
      vt[7] = '{32'hFFFF_FFC3, 32'h0000_0001, 32'h0000_0000};

      rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      check("reset led_out", {16'h0, led_out}, 32'h0);
      check("reset seg_sel", {24'h0, seg_sel}, 32'hFF);
      check("reset seg_code", {24'h0, seg_code}, 32'hFF);
      check("reset rdata", bus.rdata, 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 8; i++) begin
         busOp(vt[i].addr, vt[i].wdata, 1'b1, 1'b0, 32'h0, "");
         check($sformatf("tbl%0d led_out", i), {16'h0, led_out}, {16'h0, mLed});
         busOp(vt[i].addr, 32'h0, 1'b0, 1'b1, vt[i].exp, $sformatf("tbl%0d read", i));
      end

      @(negedge clk);
      bus.addr = A_LED; bus.wdata = 32'hFFFF_0000; bus.we = 1'b0;
      @(negedge clk);
      check("led no we", {16'h0, led_out}, 32'h0000_A5A5);

      scanCheck(0, "scan");
      busOp(A_BLANK, 32'h81, 1'b1, 1'b0, 32'h0, "");
      scanCheck(1, "blank");

      waitSel(8'hF7, ok);
      if (ok) begin
         #1 rst = 1'b0;
         #1;
         check("midreset seg_sel", {24'h0, seg_sel}, 32'hFF);
         check("midreset seg_code", {24'h0, seg_code}, 32'hFF);
         check("midreset led_out", {16'h0, led_out}, 32'h0);
         repeat (2) @(negedge clk);
         rst = 1'b1;
         mLed = '0; mSeg = '0; mBlank = '0;
         @(negedge clk);
         check("postreset sel d0", {24'h0, seg_sel}, 32'hFE);
         check("postreset code d0", {24'h0, seg_code}, 32'hC0);
         repeat (4) @(negedge clk);
         check("postreset sel d1", {24'h0, seg_sel}, 32'hFD);
         busOp(A_SEG, 32'h0, 1'b0, 1'b1, 32'h0, "postreset seg");
      end

      // Switches bounce faster than DB_CYC while confirm is pressed: the stale stable value is latched.
      for (int i = 0; i < 40; i++) begin
         sw_in = (((i / 2) % 2) == 0) ? 16'h00FF : 16'h0F00;
         confirm_in = (i >= 5 && i < 20);
         @(negedge clk);
      end
      sw_in = 16'h00FF;
      confirm_in = 1'b0;
      repeat (12) @(negedge clk);
      mPend = 1'b1;
      busOp(A_STATUS, 32'h0, 1'b0, 1'b1, 32'h1, "db pend set");
      busOp(A_SW, 32'h0, 1'b0, 1'b1, 32'h0, "db bounce rejected");
      busOp(A_STATUS, 32'h0, 1'b0, 1'b1, 32'h0, "db pend clear");
      confirm_in = 1'b1;
      repeat (12) @(negedge clk);
      busOp(A_STATUS, 32'h0, 1'b0, 1'b1, 32'h3, "db confirm held");
      mPend = 1'b1;
      confirm_in = 1'b0;
      repeat (12) @(negedge clk);
      busOp(A_STATUS, 32'h0, 1'b0, 1'b1, 32'h1, "db after release");
      busOp(A_SW, 32'h0, 1'b0, 1'b1, 32'h0000_00FF, "db sw latch");
      mSw = 16'h00FF;
      busOp(A_STATUS, 32'h0, 1'b0, 1'b1, 32'h0, "db pend cleared");
      confirm_in = 1'b1;
      repeat (2) @(negedge clk);
      confirm_in = 1'b0;
      repeat (12) @(negedge clk);
      busOp(A_STATUS, 32'h0, 1'b0, 1'b1, 32'h0, "db short pulse");

      busOp(A_SEG, 32'h0, 1'b1, 1'b0, 32'h0, "");
      busOp(A_SEG, 32'h5, 1'b1, 1'b1, 32'h0, "collide old");
      busOp(A_SEG, 32'h0, 1'b0, 1'b1, 32'h5, "collide new");

      for (int i = 0; i < 300; i++) begin
         sel = $urandom_range(0, 6);
         case (sel)
            0:       a = A_SW;
            1:       a = A_LED;
            2:       a = A_SEG;
            3:       a = A_BLANK;
            4:       a = A_STATUS;
            5:       a = $urandom;
            default: a = A_LED ^ (32'd1 << $urandom_range(0, 31));
         endcase
         d = $urandom;
         w = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 1));
         busOp(a, d, w, r, modelRead(a), $sformatf("rand%0d read %h", i, a));
         check($sformatf("rand%0d led_out", i), {16'h0, led_out}, {16'h0, mLed});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end
endmodule
